// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the in-order WB stage (A) and a
// multi-cycle unit (B): fixed A priority, with B forced ahead after STARVE_LIMIT waits.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              force_b,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic [CNT_W-1:0]  conflict_q, conflict_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              grant_a, grant_b;

  function automatic logic [3:0] sat_inc_starve(input logic [3:0] v);
    return (v == LIMIT) ? v : v + 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    force_b = (starve_q == LIMIT);
    a_ready = !(b_valid && force_b);
    b_ready = !a_valid || force_b;
    grant_a = a_valid && a_ready;
    grant_b = b_valid && b_ready;
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    // Writes to r0 are accepted from the requester but never reach the file.
    if (grant_b) begin
      if (b_addr != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = b_addr;
        rf_wdata_d = b_data;
      end
    end else if (grant_a) begin
      if (a_addr != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = a_addr;
        rf_wdata_d = a_data;
      end
    end

    if (grant_b)      starve_d = 4'd0;
    else if (b_valid) starve_d = sat_inc_starve(starve_q);
    else              starve_d = 4'd0;

    conflict_d = (a_valid && b_valid) ? sat_inc_cnt(conflict_q) : conflict_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      starve_q   <= 4'd0;
      conflict_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table followed by random traffic
// checked against a behavioural arbitration model.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LIMIT  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready, rf_we, force_b;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  conflict_cnt;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .force_b(force_b), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        chk_comb;
    logic        ea_rdy;
    logic        eb_rdy;
    logic        ef;
    logic        ewe;
    logic [4:0]  ewaddr;
    logic [31:0] ewdata;
    logic [3:0]  ecnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic cc, logic ear, logic ebr, logic ef,
                              logic ewe, logic [4:0] ewa, logic [31:0] ewd, logic [3:0] ec);
    vec_t v;
    v.rst = r; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.chk_comb = cc; v.ea_rdy = ear; v.eb_rdy = ebr; v.ef = ef;
    v.ewe = ewe; v.ewaddr = ewa; v.ewdata = ewd; v.ecnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  vec_t vecs[21];

  // Behavioural model state for the random phase
  int          b_wait;
  int          m_cnt;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  initial begin
    rst = 1'b1; a_valid = 0; a_addr = 0; a_data = 0; b_valid = 0; b_addr = 0; b_data = 0;

    //           rst av aa  ad            bv ba bd          cc ar br f  we wa  wd            cnt
    vecs[0]  = mk(1, 0, 0,  0,            0, 0, 0,          0, 1, 1, 0, 0, 0,  0,            0);
    vecs[1]  = mk(1, 0, 0,  0,            0, 0, 0,          1, 1, 1, 0, 0, 0,  0,            0);
    vecs[2]  = mk(0, 0, 0,  0,            0, 0, 0,          1, 1, 1, 0, 0, 0,  0,            0);
    vecs[3]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0, 0,          1, 1, 0, 0, 1, 5,  32'hDEADBEEF, 0);
    vecs[4]  = mk(0, 0, 0,  0,            0, 0, 0,          1, 1, 1, 0, 0, 5,  32'hDEADBEEF, 0);
    vecs[5]  = mk(0, 0, 0,  0,            1, 0, 32'h1234,   1, 1, 1, 0, 0, 5,  32'hDEADBEEF, 0);
    vecs[6]  = mk(0, 1, 1,  32'h101,      1, 7, 32'hCAFE,   1, 1, 0, 0, 1, 1,  32'h101,      1);
    vecs[7]  = mk(0, 1, 2,  32'h102,      1, 7, 32'hCAFE,   1, 1, 0, 0, 1, 2,  32'h102,      2);
    vecs[8]  = mk(0, 1, 3,  32'h103,      1, 7, 32'hCAFE,   1, 1, 0, 0, 1, 3,  32'h103,      3);
    vecs[9]  = mk(0, 1, 4,  32'h104,      1, 7, 32'hCAFE,   1, 1, 0, 0, 1, 4,  32'h104,      4);
    vecs[10] = mk(0, 1, 5,  32'h105,      1, 7, 32'hCAFE,   1, 0, 1, 1, 1, 7,  32'hCAFE,     5);
    vecs[11] = mk(0, 1, 5,  32'h105,      0, 0, 0,          1, 1, 0, 0, 1, 5,  32'h105,      5);
    vecs[12] = mk(0, 1, 3,  32'h11,       1, 3, 32'h22,     1, 1, 0, 0, 1, 3,  32'h11,       6);
    vecs[13] = mk(0, 0, 0,  0,            1, 3, 32'h22,     1, 1, 1, 0, 1, 3,  32'h22,       6);
    vecs[14] = mk(1, 1, 9,  32'h99,       0, 0, 0,          1, 1, 0, 0, 0, 0,  0,            0);
    vecs[15] = mk(0, 1, 10, 32'hA0,       1, 8, 32'hBB,     1, 1, 0, 0, 1, 10, 32'hA0,       1);
    vecs[16] = mk(0, 1, 11, 32'hA1,       1, 8, 32'hBB,     1, 1, 0, 0, 1, 11, 32'hA1,       2);
    vecs[17] = mk(0, 1, 12, 32'hA2,       1, 8, 32'hBB,     1, 1, 0, 0, 1, 12, 32'hA2,       3);
    vecs[18] = mk(0, 1, 13, 32'hA3,       1, 8, 32'hBB,     1, 1, 0, 0, 1, 13, 32'hA3,       4);
    vecs[19] = mk(0, 1, 14, 32'hA4,       1, 8, 32'hBB,     1, 0, 1, 1, 1, 8,  32'hBB,       5);
    vecs[20] = mk(0, 1, 14, 32'hA4,       0, 0, 0,          1, 1, 0, 0, 1, 14, 32'hA4,       5);

    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst;
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      @(negedge clk);
      if (vecs[i].chk_comb) begin
        chk($sformatf("v%0d a_ready", i), 64'(a_ready), 64'(vecs[i].ea_rdy));
        chk($sformatf("v%0d b_ready", i), 64'(b_ready), 64'(vecs[i].eb_rdy));
        chk($sformatf("v%0d force_b", i), 64'(force_b), 64'(vecs[i].ef));
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d rf_we", i),        64'(rf_we),        64'(vecs[i].ewe));
      chk($sformatf("v%0d rf_waddr", i),     64'(rf_waddr),     64'(vecs[i].ewaddr));
      chk($sformatf("v%0d rf_wdata", i),     64'(rf_wdata),     64'(vecs[i].ewdata));
      chk($sformatf("v%0d conflict_cnt", i), 64'(conflict_cnt), 64'(vecs[i].ecnt));
    end

    // Random traffic: B holds its request until granted, A is free-running.
    rst = 1'b1; a_valid = 0; b_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    b_wait = 0; m_cnt = 0; m_we = 0; m_waddr = 0; m_wdata = 0;

    for (int c = 0; c < 400; c++) begin
      logic exp_force, exp_ar, exp_br, win_a, win_b;
      if (!b_valid && $urandom_range(0, 2) == 0) begin
        b_valid = 1'b1;
        b_addr  = 5'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      a_valid = ($urandom_range(0, 3) != 0);
      a_addr  = 5'($urandom_range(0, 31));
      a_data  = $urandom;

      exp_force = (b_wait == LIMIT);
      exp_ar = !(b_valid && exp_force);
      exp_br = !a_valid || exp_force;
      // B wins if it has waited out its limit, otherwise A has priority.
      win_b = b_valid && (exp_force || !a_valid);
      win_a = a_valid && !win_b;

      @(negedge clk);
      chk("rnd a_ready", 64'(a_ready), 64'(exp_ar));
      chk("rnd b_ready", 64'(b_ready), 64'(exp_br));
      chk("rnd force_b", 64'(force_b), 64'(exp_force));
      @(posedge clk); #1;

      m_we = 1'b0;
      if (win_b && b_addr != 0) begin m_we = 1'b1; m_waddr = b_addr; m_wdata = b_data; end
      if (win_a && a_addr != 0) begin m_we = 1'b1; m_waddr = a_addr; m_wdata = a_data; end
      if (a_valid && b_valid && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (win_b || !b_valid) b_wait = 0;
      else if (b_wait < LIMIT) b_wait++;

      chk("rnd rf_we",        64'(rf_we),        64'(m_we));
      chk("rnd rf_waddr",     64'(rf_waddr),     64'(m_waddr));
      chk("rnd rf_wdata",     64'(rf_wdata),     64'(m_wdata));
      chk("rnd conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      if (win_b) b_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
